fetch_pc_unit: RTL and testbench

Instruction-fetch stage front end for the five-stage RISC-V core. Holds the program counter and computes the sequential next PC (PC+4) with the half-adder incrementer chain. Drives the instruction-memory address and captures the fetched word into the IF/ID pipeline register. Stalls and flushes come from the hazard and branch logic downstream.

---
 rtl/fetch_pc_unit.sv | 96 +++++++++
 tb/tb_fetch_pc_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: program counter, half-adder PC+4 chain and IF/ID pipeline register.
// Redirects flush IF/ID with a NOP bubble; stalls freeze PC, IF/ID and the fetch counter.
module fetch_pc_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic            misalign,
    output logic [31:0]     fetch_count
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_pc4_q, if_id_pc4_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic            carry;

    // Ripple of half adders from bit 2 with carry-in 1; carry out of the MSB is dropped.
    always_comb begin
        pc4   = pc_q;
        carry = 1'b1;
        for (int i = 2; i < XLEN; i++) begin
            pc4[i] = pc_q[i] ^ carry;
            carry  = pc_q[i] & carry;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;
        if (redirect) begin
            // Redirect wins over stall; IF/ID PCs are left untouched under the bubble.
            pc_d          = {redirect_pc[XLEN-1:2], 2'b00};
            misalign_d    = (redirect_pc[1:0] != 2'b00);
            if_id_valid_d = 1'b0;
            if_id_instr_d = Nop;
        end else if (!stall) begin
            pc_d          = pc4;
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc4;
            if_id_instr_d = imem_rdata[31:0];
            if_id_valid_d = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_pc4_q   <= '0;
            if_id_instr_q <= Nop;
            if_id_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign misalign    = misalign_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: free-run, stall, redirect, wrap-around, misalign, async reset.
// Instruction memory returns 0xABCD_0000 | addr[15:0] so each fetched word identifies its address.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = {16'hABCD, imem_addr[15:0]};

    fetch_pc_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .misalign    (misalign),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                             input logic [31:0] ipc4, input logic [31:0] instr,
                             input logic valid, input logic mis, input logic [31:0] cnt);
        chk({tag, ".pc"},    imem_addr,   pc);
        chk({tag, ".ipc"},   if_id_pc,    ipc);
        chk({tag, ".ipc4"},  if_id_pc4,   ipc4);
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
        chk({tag, ".mis"},   {31'd0, misalign},    {31'd0, mis});
        chk({tag, ".cnt"},   fetch_count, cnt);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        chk_state("reset", 32'h0, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0, 32'd0);
        step();
        rst = 1'b0;

        // Free run from 0
        step();
        chk_state("run1", 32'h4, 32'h0, 32'h4, 32'hABCD_0000, 1'b1, 1'b0, 32'd1);
        step();
        chk("run2.pc", imem_addr, 32'h8);
        chk("run2.ipc", if_id_pc, 32'h4);
        step();
        chk("run3.pc", imem_addr, 32'hC);
        step();
        chk_state("run4", 32'h10, 32'hC, 32'h10, 32'hABCD_000C, 1'b1, 1'b0, 32'd4);

        // Stall three cycles at pc = 0x10
        stall = 1'b1;
        step();
        chk_state("stall1", 32'h10, 32'hC, 32'h10, 32'hABCD_000C, 1'b1, 1'b0, 32'd4);
        step();
        step();
        chk_state("stall3", 32'h10, 32'hC, 32'h10, 32'hABCD_000C, 1'b1, 1'b0, 32'd4);
        stall = 1'b0;
        step();
        chk_state("unstall", 32'h14, 32'h10, 32'h14, 32'hABCD_0010, 1'b1, 1'b0, 32'd5);

        // Advance to pc = 0x20, then redirect to 0x100
        step();
        step();
        step();
        chk("pre_redir.pc", imem_addr, 32'h20);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk_state("redir", 32'h100, 32'h1C, 32'h20, 32'h13, 1'b0, 1'b0, 32'd8);
        step();
        chk_state("redir+1", 32'h104, 32'h100, 32'h104, 32'hABCD_0100, 1'b1, 1'b0, 32'd9);

        // Redirect with stall: stall dropped
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        chk_state("redir_stall", 32'h40, 32'h100, 32'h104, 32'h13, 1'b0, 1'b0, 32'd9);
        step();
        chk_state("redir_stall+1", 32'h44, 32'h40, 32'h44, 32'hABCD_0040, 1'b1, 1'b0, 32'd10);

        // Wrap-around at top of address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("wrap0.pc", imem_addr, 32'hFFFF_FFFC);
        step();
        chk_state("wrap1", 32'h0, 32'hFFFF_FFFC, 32'h0, 32'hABCD_FFFC, 1'b1, 1'b0, 32'd11);
        step();
        chk_state("wrap2", 32'h4, 32'h0, 32'h4, 32'hABCD_0000, 1'b1, 1'b0, 32'd12);

        // Misaligned redirect; misalign is sticky until the next redirect
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        chk("mis.pc", imem_addr, 32'h100);
        chk("mis.flag", {31'd0, misalign}, 32'd1);
        step();
        chk("mis_sticky.flag", {31'd0, misalign}, 32'd1);
        chk("mis_sticky.pc", imem_addr, 32'h104);
        chk("mis_sticky.cnt", fetch_count, 32'd13);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        chk("mis_clr.flag", {31'd0, misalign}, 32'd0);
        chk("mis_clr.pc", imem_addr, 32'h200);
        step();
        chk("pre_rst.pc", imem_addr, 32'h204);

        // Asynchronous reset mid-cycle, away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 32'h0, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk_state("post_rst", 32'h4, 32'h0, 32'h4, 32'hABCD_0000, 1'b1, 1'b0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
